// File: rtl/result_checker.sv
// Compares the processor Result stream against a preloaded expected table and counts passes/fails.
// Optional build macro RESULT_CHK_HALT_ON_FAIL_EN: the first mismatch ends the run.
module result_checker #(
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 20,
    parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    parameter int CNT_W      = $clog2(NUM_CHECKS + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_exp_we,
    input  logic [IDX_W-1:0]  i_exp_addr,
    input  logic [DATA_W-1:0] i_exp_data,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_result_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_all_pass,
    output logic [CNT_W-1:0]  o_pass_count,
    output logic [CNT_W-1:0]  o_fail_count,
    output logic              o_first_fail_valid,
    output logic [IDX_W-1:0]  o_first_fail_idx,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_CHECKS - 1);

`ifdef RESULT_CHK_HALT_ON_FAIL_EN
    localparam bit LP_HALT = 1'b1;
`else
    localparam bit LP_HALT = 1'b0;
`endif

    logic [DATA_W-1:0] r_exp [NUM_CHECKS];
    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_pass_count;
    logic [CNT_W-1:0]  r_fail_count;
    logic              r_first_fail_valid;
    logic [IDX_W-1:0]  r_first_fail_idx;
    logic              r_done;

    logic              w_in_check;
    logic              w_sample;
    logic              w_match;
    logic              w_last;
    logic              w_end;
    logic              w_addr_ok;
    logic              w_tbl_we;
    logic [1:0]        w_state_nxt;

    // Valid-only stream, no back-pressure: a word is consumed on every CHECK
    // cycle where i_result_valid is high; start on the same cycle drops it.
    assign w_in_check = (r_state == ST_CHECK);
    assign w_sample   = w_in_check && i_result_valid && !i_start;
    assign w_match    = (i_result == r_exp[r_idx]);
    assign w_last     = (r_idx == LP_LAST_IDX);
    assign w_end      = w_sample && (w_last || (LP_HALT && !w_match));

    // The table is frozen while a run is in progress.
    assign w_addr_ok  = (32'(i_exp_addr) < 32'(NUM_CHECKS));
    assign w_tbl_we   = i_exp_we && w_addr_ok && !w_in_check;

    always_comb begin
        w_state_nxt = r_state;
        if (i_start) begin
            w_state_nxt = ST_CHECK;
        end else if (w_end) begin
            w_state_nxt = ST_DONE;
        end
    end

    // Table storage deliberately has no reset so contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (w_tbl_we) begin
            r_exp[i_exp_addr] <= i_exp_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx              <= '0;
            r_pass_count       <= '0;
            r_fail_count       <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_idx   <= '0;
            r_done             <= 1'b0;
        end else if (i_start) begin
            r_idx              <= '0;
            r_pass_count       <= '0;
            r_fail_count       <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_idx   <= '0;
            r_done             <= 1'b0;
        end else if (w_sample) begin
            if (w_match) begin
                r_pass_count <= r_pass_count + CNT_W'(1);
            end else begin
                r_fail_count <= r_fail_count + CNT_W'(1);
                if (!r_first_fail_valid) begin
                    r_first_fail_valid <= 1'b1;
                    r_first_fail_idx   <= r_idx;
                end
            end
            // Hold idx at the last entry so it never walks off the table.
            if (!w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_end) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_busy             = w_in_check;
    assign o_done             = r_done;
    assign o_all_pass         = r_done && (r_fail_count == '0);
    assign o_pass_count       = r_pass_count;
    assign o_fail_count       = r_fail_count;
    assign o_first_fail_valid = r_first_fail_valid;
    assign o_first_fail_idx   = r_first_fail_idx;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: golden table model plus a count scoreboard.
module tb_result_checker;

    localparam int DW = 32;
    localparam int NC = 20;
    localparam int IW = 5;
    localparam int CW = 5;
    localparam int W  = 2 * CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          exp_we;
    logic [IW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          start;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          done;
    logic          all_pass;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;
    logic          first_fail_valid;
    logic [IW-1:0] first_fail_idx;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  exp_q [$];
    logic [DW-1:0] gold  [NC];

    int m_state;
    int m_idx;
    int m_pass;
    int m_fail;
    bit m_ffv;
    int m_ffi;
    bit m_halt;

    result_checker #(.DATA_W(DW), .NUM_CHECKS(NC)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_exp_we           (exp_we),
        .i_exp_addr         (exp_addr),
        .i_exp_data         (exp_data),
        .i_start            (start),
        .i_result           (result),
        .i_result_valid     (result_valid),
        .o_busy             (busy),
        .o_done             (done),
        .o_all_pass         (all_pass),
        .o_pass_count       (pass_count),
        .o_fail_count       (fail_count),
        .o_first_fail_valid (first_fail_valid),
        .o_first_fail_idx   (first_fail_idx),
        .o_dbg_state        (dbg_state)
    );

    // Clock and reset-independent timing helpers
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    task automatic model_clear();
        m_idx  = 0;
        m_pass = 0;
        m_fail = 0;
        m_ffv  = 1'b0;
        m_ffi  = 0;
    endtask

    // Drive one cycle of the result stream and score the counters after the edge.
    task automatic send(input bit v, input logic [DW-1:0] d);
        logic [W-1:0] e;
        bit mism;
        result_valid = v;
        result       = d;
        if (m_state == 1 && v) begin
            mism = (d !== gold[m_idx]);
            if (!mism) begin
                m_pass++;
            end else begin
                m_fail++;
                if (!m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffi = m_idx;
                end
            end
            if (m_idx == NC - 1 || (m_halt && mism)) m_state = 2;
            else m_idx++;
        end
        exp_q.push_back({CW'(m_pass), CW'(m_fail)});
        tick();
        result_valid = 1'b0;
        e = exp_q.pop_front();
        chk("counts", {pass_count, fail_count}, e);
        chk("busy", busy, (m_state == 1));
        chk("done", done, (m_state == 2));
    endtask

    task automatic do_start(input bit with_valid);
        start        = 1'b1;
        result_valid = with_valid;
        result       = 32'hDEAD_BEEF;
        m_state      = 1;
        model_clear();
        tick();
        start        = 1'b0;
        result_valid = 1'b0;
        chk("start_counts", {pass_count, fail_count}, '0);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_ffv", first_fail_valid, 0);
    endtask

    task automatic final_check(input string tag);
        chk({tag, "_pass"}, pass_count, m_pass);
        chk({tag, "_fail"}, fail_count, m_fail);
        chk({tag, "_ffv"}, first_fail_valid, m_ffv);
        chk({tag, "_ffi"}, first_fail_idx, m_ffi);
        chk({tag, "_done"}, done, (m_state == 2));
        chk({tag, "_allpass"}, all_pass, (m_state == 2 && m_fail == 0));
        chk({tag, "_state"}, dbg_state, m_state);
    endtask

    task automatic stream(input int bad_idx, input logic [DW-1:0] bad_val, input int gap_after);
        for (int i = 0; i < NC; i++) begin
            send(1'b1, (i == bad_idx) ? bad_val : gold[i]);
            if (i == gap_after) begin
                for (int g = 0; g < 3; g++) send(1'b0, 32'h0);
            end
        end
    endtask

    initial begin
        gold = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hB, 32'h3, 32'hFFFF_FFFE,
                 32'h0, 32'h5, 32'h1, 32'hFFFF_FFF4, 32'h4D2, 32'hFFFF_F8D7, 32'h1, 32'hFFFF_FB2C,
                 32'h30, 32'h30};
`ifdef RESULT_CHK_HALT_ON_FAIL_EN
        m_halt = 1'b1;
`else
        m_halt = 1'b0;
`endif
        reset = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        start = 1'b0; result = '0; result_valid = 1'b0;
        m_state = 0;
        model_clear();
        tick();
        tick();
        final_check("reset");
        chk("reset_busy", busy, 0);
        reset = 1'b0;

        // Load the table in IDLE, including one out-of-range address.
        for (int i = 0; i < NC; i++) begin
            exp_we = 1'b1; exp_addr = IW'(i); exp_data = gold[i];
            tick();
        end
        exp_addr = 5'd31; exp_data = 32'h1234_5678;
        tick();
        exp_we = 1'b0;
        send(1'b1, 32'h0);

        // Test 1: clean run
        do_start(1'b0);
        stream(-1, 32'h0, -1);
        final_check("t1");

        // Test 2: word 9 corrupted
        do_start(1'b0);
        stream(9, 32'hFFFF_FFFF, -1);
        final_check("t2");

        // Test 3: three idle cycles after word 4
        do_start(1'b0);
        stream(-1, 32'h0, 4);
        final_check("t3");

        // Test 4: reset mid-run, then a full run on the retained table
        do_start(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, gold[i]);
        reset = 1'b1;
        m_state = 0;
        model_clear();
        tick();
        reset = 1'b0;
        final_check("t4_reset");
        chk("t4_busy", busy, 0);
        send(1'b1, 32'h0);
        do_start(1'b0);
        stream(-1, 32'h0, -1);
        final_check("t4");

        // Test 5: table write in CHECK ignored, restart after 7 words, start beats valid
        do_start(1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                exp_we = 1'b1; exp_addr = 5'd1; exp_data = 32'h1234_5678;
            end
            send(1'b1, gold[i]);
            exp_we = 1'b0;
        end
        do_start(1'b1);
        stream(-1, 32'h0, -1);
        final_check("t5");

        // Test 6: mismatch at idx 3 (halts only when the macro is defined)
        do_start(1'b0);
        stream(3, 32'h5, -1);
        final_check("t6");

        // Samples in DONE are ignored
        send(1'b1, 32'hFFFF_FFFF);
        final_check("t6_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
